serial_mul_div: RTL
===================

Name: serial_mul_div

Overview:
- Iterative RV32M execute unit: multiply (shift-add) and divide (restoring), one bit per cycle.
- Sits beside the ALU in the execute stage.
- Its result feeds the writeback-select 2x1 mux (ALU result vs. M-unit result).
- busy stalls the PC/pipeline until done.

Parameters:
- WIDTH, 32, operand/result width. Must be even and >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- op  input  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  WIDTH  multiplicand / dividend.
- rs2  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result is valid.
- result  output  WIDTH  registered result. Held until the next accepted start completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0, result=0.
  - All internal registers cleared.
  - Any in-flight operation is discarded and produces no done.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE:
  - done=0 except the single cycle following FIX.
  - On start=1 at edge E0:
    - latch op;
    - latch the absolute values of rs1/rs2 when the op treats that operand as signed (MULH: both; MULHSU: rs1 only; DIV/REM: both);
    - latch the result-sign flag;
    - clear the accumulator, iteration counter = 0, busy<=1, state<=CALC.
  - start=0 leaves IDLE unchanged.
- CALC, edges E1..E32 (WIDTH iterations), one bit per edge, counter increments.
  - Multiply: 2*WIDTH-bit product accumulator. If the multiplier LSB is 1, add the multiplicand into the upper half, then shift right 1 with carry.
  - Divide: restoring. Shift {remainder,dividend} left 1. If remainder >= divisor, subtract and set quotient LSB=1.
  - On the edge where counter = WIDTH-1: state<=FIX.
- FIX, edge E33:
  - Apply sign correction (two's-complement negate if the sign flag is set).
  - Select the output word:
    - MUL: low word.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - result<=word, done<=1, busy<=0, state<=IDLE.
- Latency:
  - done is high in the cycle after E33, i.e. 34 edges after the start edge.
  - Latency is fixed for every op and every operand value, including the special cases below.
- Back-to-back: start asserted in the cycle where done=1 is accepted at the next edge.
- start while busy=1 is ignored (no queueing). rs1/rs2/op changes while busy have no effect.
- Sign rules:
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder sign = sign(rs1).
  - MULH product sign = XOR of the operand signs. MULHSU product sign = sign(rs1).
- Special cases, detected at start and applied in FIX (override the datapath):
  - Divide by zero (rs2=0):
    - DIV/DIVU result = all ones (0xFFFFFFFF);
    - REM/REMU result = rs1 unchanged.
  - Signed overflow (DIV/REM, rs1=most-negative, rs2=all ones):
    - DIV result = most-negative (0x80000000);
    - REM result = 0.
- Width rules: product accumulator 2*WIDTH bits; remainder/subtractor WIDTH+1 bits; counter clog2(WIDTH) bits.
- busy and done are never high in the same cycle.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done 34 edges after start, result=0xFFFFFFEB. MULHU same operands -> 0x00000006.
- MULH rs1=rs2=0x80000000 -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIV 0x64/0 -> 0xFFFFFFFF; REMU 0x64/0 -> 0x00000064; latency still 34 edges.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
- Control:
  - start re-pulsed with new operands at E10 -> ignored; original result returned at E33.
  - Second start in the done cycle -> accepted, busy=1 the next cycle.
  - rst=0 at E15 -> busy=0, result=0 immediately, no done pulse.

Source files
------------

// File: rtl/serial_mul_div.sv
// serial_mul_div -- iterative RV32M execute unit.
//
// Multiplies by shift-add and divides by restoring division, one bit per
// clock. Every operation takes the same number of cycles regardless of op or
// operand values; the result register feeds the writeback-select mux and busy
// stalls the pipeline until the done pulse.
//
// Ports
//   clk     system clock, rising edge
//   rst     asynchronous, active-low reset
//   start   request, sampled only while idle
//   op      funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1     multiplicand / dividend
//   rs2     multiplier / divisor
//   busy    operation in progress
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next operation completes

module serial_mul_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [2:0]         op_q, op_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;      // multiplicand, or divisor for divides
   logic [2*WIDTH-1:0] acc_q, acc_d;          // {hi, lo} product or {remainder, dividend/quotient}
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;          // negate the selected result in FIX
   logic               spec_q, spec_d;        // special case: spec_val overrides the datapath
   logic [WIDTH-1:0]   spec_val_q, spec_val_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   // Operand decode at start
   logic             rs1_signed, rs2_signed, s1, s2, div0, ovf;
   logic [WIDTH-1:0] abs1, abs2;
   // Iteration datapath
   logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
   logic             rem_ge;
   // Result selection
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   div_word, div_fix, fix_word;

   always_comb begin
      rs1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      rs2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      s1   = rs1_signed & rs1[WIDTH-1];
      s2   = rs2_signed & rs2[WIDTH-1];
      abs1 = s1 ? (~rs1 + 1'b1) : rs1;
      abs2 = s2 ? (~rs2 + 1'b1) : rs2;
      div0 = (rs2 == '0);
      ovf  = ((op == 3'b100) || (op == 3'b110)) && (rs1 == MOST_NEG) && (&rs2);

      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};

      // Restoring step: the borrow bit of the (WIDTH+1)-bit difference is
      // set exactly when the shifted remainder is below the divisor.
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, mcand_q};
      rem_ge   = ~rem_diff[WIDTH];

      // Product sign must be applied to the full double-width value before
      // the high word is taken.
      prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
      div_word = op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
      div_fix  = neg_q ? (~div_word + 1'b1) : div_word;
      if (spec_q)
         fix_word = spec_val_q;
      else if (op_q[2])
         fix_word = div_fix;
      else if (op_q == 3'b000)
         fix_word = prod_fix[WIDTH-1:0];
      else
         fix_word = prod_fix[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mcand_d    = mcand_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      neg_d      = neg_q;
      spec_d     = spec_q;
      spec_val_d = spec_val_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = op;
               // Divides keep the divisor in mcand and the dividend in the
               // low accumulator half; multiplies keep the multiplier there.
               mcand_d = op[2] ? abs2 : abs1;
               acc_d   = {{WIDTH{1'b0}}, (op[2] ? abs1 : abs2)};
               case (op)
                  3'b001, 3'b100: neg_d = s1 ^ s2;
                  3'b010, 3'b110: neg_d = s1;
                  default:        neg_d = 1'b0;
               endcase
               spec_d = op[2] & (div0 | ovf);
               if (div0)
                  spec_val_d = op[1] ? rs1 : {WIDTH{1'b1}};
               else
                  spec_val_d = op[1] ? {WIDTH{1'b0}} : MOST_NEG;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            if (op_q[2])
               acc_d = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], rem_ge};
            else
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST)
               state_d = S_FIX;
         end
         S_FIX: begin
            result_d = fix_word;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         mcand_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         neg_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         mcand_q    <= mcand_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         neg_q      <= neg_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
